car_direction_detector: RTL and testbench
=========================================

# car_direction_detector

Upstream front end for `parking_lot_occupancy_counter`. It synchronizes and debounces the two raw optical sensors (A outer, B inner) and runs a direction state machine. The output is one single-cycle `car_enter_o` or `car_exit_o` pulse per completed, legal passage. The counter consumes only these pulses and never sees raw sensor levels. Illegal sensor sequences are rejected and flagged, so noise or a car backing out never changes the count.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive cycles a synchronized sensor level must differ from its debounced level before the debounced level updates; minimum 1.
- `clk_i`  in  1  system clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `sensor_a_i`  in  1  raw outer sensor, asynchronous; 1 = beam blocked.
- `sensor_b_i`  in  1  raw inner sensor, asynchronous; 1 = beam blocked.
- `car_enter_o`  out  1  one-cycle pulse: a car completed an entry.
- `car_exit_o`  out  1  one-cycle pulse: a car completed an exit.
- `seq_error_o`  out  1  one-cycle pulse: an illegal sensor transition was detected.

## Operation
- Per sensor: 2-FF synchronizer, then debouncer. Each sensor has its own counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If sync equals debounced: count clears to 0.
  - Else if count = `DEBOUNCE_CYCLES-1`: debounced takes sync and count clears.
  - Else: count increments.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches the FSM.
- The FSM input is the debounced pair {A,B}. States and moves:
  - IDLE (00): on 10 go to IN_A; on 01 go to OUT_B; on 11 go to ABORT with an error pulse.
  - IN_A (10): on 11 go to IN_AB; on 00 go to IDLE, no pulse (the car backed off).
  - IN_AB (11): on 01 go to IN_B; on 10 go back to IN_A.
  - IN_B (01): on 00 go to IDLE with a `car_enter_o` pulse; on 11 go back to IN_AB.
  - The exit path mirrors this: OUT_B (01), then OUT_AB (11), then OUT_A (10), then 00 goes to IDLE with a `car_exit_o` pulse. The same backward steps are allowed.
  - Any other change from an active state, i.e. both bits flipping at once: go to ABORT with a `seq_error_o` pulse.
  - ABORT: stay until the pair is 00, then go to IDLE. No further error pulses while in ABORT.
- At most one output pulse is high in any cycle. Enter and exit are never both asserted.
- A held pair produces no pulse. Each pulse corresponds to exactly one state transition.

## Timing
- Reset values: all outputs 0, synchronizers 0, debounced levels 0, counters 0, state IDLE.
- Sync latency: a raw change is visible at the second synchronizer output 2 edges after the first sampling edge.
- Debounce latency: the debounced level updates `DEBOUNCE_CYCLES` edges later if the raw level is held. Total latency is `DEBOUNCE_CYCLES+2` edges.
- Output latency: the FSM state and output pulses are registered. A pulse is high for exactly the one cycle following the edge at which the debounced pair produced the qualifying transition.
- Sensors blocked at reset release: the debounced levels rise after the normal latency.
  - Both blocked: IDLE sees 11, goes to ABORT, one error pulse.
  - Only A blocked: entry tracking starts normally.
- Reset mid-sequence returns to IDLE with no pulse. The aborted car is not counted.
- Both debounced bits may change on the same edge. This is legal only as a transition listed in Operation; otherwise it goes to ABORT.

## Structure
- Shared package `parking_pkg`:
  - `dir_state_t` enum: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, ABORT.
  - Sensor-pair localparams: `PAIR_CLEAR=2'b00`, `PAIR_A=2'b10`, `PAIR_B=2'b01`, `PAIR_BOTH=2'b11`.
- Sub-module `sensor_debouncer`, parameterized by `DEBOUNCE_CYCLES`, containing synchronizer, counter and debounced register. It is instantiated twice.
- The top of `car_direction_detector` holds the FSM and the registered pulse outputs.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` and raw levels held at least 8 cycles per step unless noted.
- Entry: raw A,B = 00 → 10 → 11 → 01 → 00. Exactly one `car_enter_o` pulse, 7 edges after the final raw release (6-edge debounce latency plus 1 registered edge); no exit or error pulse.
- Exit: 00 → 01 → 11 → 10 → 00. Exactly one `car_exit_o` pulse; no other pulses.
- Backout: 00 → 10 → 11 → 10 → 00. No pulses; state IDLE at end.
- Glitch rejection: 3-cycle pulse on A while idle. No state change; debounced A stays 0.
- Illegal jump: 00 → 10 → 01. One `seq_error_o` pulse, then ABORT. A later 11 gives no further pulse; 00 returns to IDLE. A following legal entry still counts once.
- Reset mid-entry: assert `reset_i` for 1 cycle while in IN_AB, then continue 01 → 00. No enter pulse; all outputs 0 during and after reset.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types for the parking-lot front end: direction FSM states and debounced sensor-pair codes.
// Pair bit order is {A (outer), B (inner)}.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IN_A,
        IN_AB,
        IN_B,
        OUT_B,
        OUT_AB,
        OUT_A,
        ABORT
    } dir_state_t;

    localparam logic [1:0] PAIR_CLEAR = 2'b00;
    localparam logic [1:0] PAIR_A     = 2'b10;
    localparam logic [1:0] PAIR_B     = 2'b01;
    localparam logic [1:0] PAIR_BOTH  = 2'b11;

endpackage

// File: rtl/sensor_debouncer.sv
// Two-flop synchronizer followed by a hold-time debouncer for one optical sensor.
// A level change reaches the output DEBOUNCE_CYCLES+2 edges after it is first sampled.
module sensor_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            // Any return to the current level restarts the hold window.
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_q2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/car_direction_detector.sv
// Debounces the outer (A) and inner (B) sensors and tracks the passage direction,
// emitting one registered single-cycle pulse per completed entry, exit or illegal transition.
module car_direction_detector
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sensor_a_i,
    input  logic sensor_b_i,
    output logic car_enter_o,
    output logic car_exit_o,
    output logic seq_error_o
);

    logic       deb_a;
    logic       deb_b;
    logic [1:0] pair;

    sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk   (clk_i),
        .reset (reset_i),
        .raw   (sensor_a_i),
        .level (deb_a)
    );

    sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk   (clk_i),
        .reset (reset_i),
        .raw   (sensor_b_i),
        .level (deb_b)
    );

    assign pair = {deb_a, deb_b};

    dir_state_t state_q;
    dir_state_t state_d;
    logic       enter_d;
    logic       exit_d;
    logic       error_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            car_enter_o <= 1'b0;
            car_exit_o  <= 1'b0;
            seq_error_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            car_enter_o <= enter_d;
            car_exit_o  <= exit_d;
            seq_error_o <= error_d;
        end
    end

    // Each active state accepts a step forward, a step back, or a hold; anything else aborts.
    always_comb begin
        state_d = state_q;
        enter_d = 1'b0;
        exit_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            IDLE: begin
                case (pair)
                    PAIR_A:    state_d = IN_A;
                    PAIR_B:    state_d = OUT_B;
                    PAIR_BOTH: begin state_d = ABORT; error_d = 1'b1; end
                    default:   ;
                endcase
            end
            IN_A: begin
                case (pair)
                    PAIR_BOTH:  state_d = IN_AB;
                    PAIR_CLEAR: state_d = IDLE;
                    PAIR_B:     begin state_d = ABORT; error_d = 1'b1; end
                    default:    ;
                endcase
            end
            IN_AB: begin
                case (pair)
                    PAIR_B:     state_d = IN_B;
                    PAIR_A:     state_d = IN_A;
                    PAIR_CLEAR: begin state_d = ABORT; error_d = 1'b1; end
                    default:    ;
                endcase
            end
            IN_B: begin
                case (pair)
                    PAIR_CLEAR: begin state_d = IDLE; enter_d = 1'b1; end
                    PAIR_BOTH:  state_d = IN_AB;
                    PAIR_A:     begin state_d = ABORT; error_d = 1'b1; end
                    default:    ;
                endcase
            end
            OUT_B: begin
                case (pair)
                    PAIR_BOTH:  state_d = OUT_AB;
                    PAIR_CLEAR: state_d = IDLE;
                    PAIR_A:     begin state_d = ABORT; error_d = 1'b1; end
                    default:    ;
                endcase
            end
            OUT_AB: begin
                case (pair)
                    PAIR_A:     state_d = OUT_A;
                    PAIR_B:     state_d = OUT_B;
                    PAIR_CLEAR: begin state_d = ABORT; error_d = 1'b1; end
                    default:    ;
                endcase
            end
            OUT_A: begin
                case (pair)
                    PAIR_CLEAR: begin state_d = IDLE; exit_d = 1'b1; end
                    PAIR_BOTH:  state_d = OUT_AB;
                    PAIR_B:     begin state_d = ABORT; error_d = 1'b1; end
                    default:    ;
                endcase
            end
            ABORT: begin
                if (pair == PAIR_CLEAR) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_car_direction_detector.sv
// Directed scenarios plus randomized sensor sequences, checked every cycle against a path-position model.
module tb_car_direction_detector;

    localparam int D   = 4;
    localparam int LAT = D + 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sensor_a = 1'b0;
    logic sensor_b = 1'b0;
    logic car_enter, car_exit, seq_error;

    always #5 clk = ~clk;

    car_direction_detector #(.DEBOUNCE_CYCLES(D)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .sensor_a_i  (sensor_a),
        .sensor_b_i  (sensor_b),
        .car_enter_o (car_enter),
        .car_exit_o  (car_exit),
        .seq_error_o (seq_error)
    );

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int n_enter = 0, n_exit = 0, n_err = 0;
    logic [2:0] exp_ev [int];

    // Model: direction (0 none, 1 entering, 2 exiting, 3 aborted) and position on a
    // 4-slot cyclic path whose slot 0 is the clear pair.
    logic [1:0] m_pair = 2'b00;
    int m_dir = 0;
    int m_pos = 0;
    logic [1:0] path_in  [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] path_out [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    function automatic int path_index(int dir, logic [1:0] p);
        for (int k = 0; k < 4; k++) begin
            if ((dir == 1 && path_in[k] == p) || (dir == 2 && path_out[k] == p)) return k;
        end
        return -1;
    endfunction

    task automatic check_bits(string tag, logic [2:0] obs, logic [2:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s @cycle %0d: observed %b expected %b", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_int(string tag, int obs, int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_step(logic [1:0] np, int c);
        logic [2:0] ev;
        int q;
        ev = 3'b000;
        if (np == m_pair) return;
        if (m_dir == 3) begin
            if (np == 2'b00) m_dir = 0;
        end else if (m_dir == 0) begin
            if (np == 2'b11) begin m_dir = 3; ev = 3'b001; end
            else if (np == 2'b10) begin m_dir = 1; m_pos = 1; end
            else if (np == 2'b01) begin m_dir = 2; m_pos = 1; end
        end else begin
            q = path_index(m_dir, np);
            if ((q - m_pos + 4) % 4 == 1 || (m_pos - q + 4) % 4 == 1) begin
                if (q == 0) begin
                    if (m_pos == 3) ev = (m_dir == 1) ? 3'b100 : 3'b010;
                    m_dir = 0;
                end else begin
                    m_pos = q;
                end
            end else begin
                m_dir = 3;
                ev = 3'b001;
            end
        end
        m_pair = np;
        if (ev != 3'b000) exp_ev[c + LAT] = ev;
    endtask

    task automatic tick();
        logic [2:0] expv;
        @(posedge clk);
        cyc++;
        #1;
        expv = exp_ev.exists(cyc) ? exp_ev[cyc] : 3'b000;
        check_bits("pulses{enter,exit,err}", {car_enter, car_exit, seq_error}, expv);
        if (car_enter) n_enter++;
        if (car_exit) n_exit++;
        if (seq_error) n_err++;
    endtask

    // Drive a pair for 'hold' cycles, optionally with a short glitch on one sensor mid-hold.
    task automatic run_step(logic [1:0] p, int hold, int glen, logic [1:0] gmask);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            reset = 1'b0;
            if (glen > 0 && i >= 7 && i < 7 + glen) {sensor_a, sensor_b} = p ^ gmask;
            else {sensor_a, sensor_b} = p;
            if (i == 0) model_step(p, cyc + 1);
            tick();
        end
    endtask

    task automatic do_reset(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b1;
            exp_ev.delete();
            m_pair = 2'b00;
            m_dir = 0;
            m_pos = 0;
            tick();
        end
    endtask

    task automatic expect_counts(string tag, int e0, int x0, int r0, int de, int dx, int dr);
        check_int({tag, " enter"}, n_enter - e0, de);
        check_int({tag, " exit"},  n_exit - x0,  dx);
        check_int({tag, " error"}, n_err - r0,   dr);
    endtask

    initial begin
        int e0, x0, r0;
        logic [1:0] rp;
        int rh, rg;
        logic [1:0] rm;

        do_reset(3);
        run_step(2'b00, 10, 0, 2'b00);

        // Entry
        e0 = n_enter; x0 = n_exit; r0 = n_err;
        run_step(2'b10, 10, 0, 2'b00);
        run_step(2'b11, 10, 0, 2'b00);
        run_step(2'b01, 10, 0, 2'b00);
        run_step(2'b00, 12, 0, 2'b00);
        expect_counts("entry", e0, x0, r0, 1, 0, 0);

        // Exit
        e0 = n_enter; x0 = n_exit; r0 = n_err;
        run_step(2'b01, 10, 0, 2'b00);
        run_step(2'b11, 10, 0, 2'b00);
        run_step(2'b10, 10, 0, 2'b00);
        run_step(2'b00, 12, 0, 2'b00);
        expect_counts("exit", e0, x0, r0, 0, 1, 0);

        // Backout, glitch while idle, then a full entry proves the FSM is still idle
        e0 = n_enter; x0 = n_exit; r0 = n_err;
        run_step(2'b10, 10, 0, 2'b00);
        run_step(2'b11, 10, 0, 2'b00);
        run_step(2'b10, 10, 0, 2'b00);
        run_step(2'b00, 14, 3, 2'b10);
        run_step(2'b00, 14, 2, 2'b01);
        expect_counts("backout+glitch", e0, x0, r0, 0, 0, 0);
        run_step(2'b10, 10, 0, 2'b00);
        run_step(2'b11, 10, 0, 2'b00);
        run_step(2'b01, 10, 0, 2'b00);
        run_step(2'b00, 12, 0, 2'b00);
        expect_counts("entry after backout", e0, x0, r0, 1, 0, 0);

        // Illegal jump, held abort, then a legal entry
        e0 = n_enter; x0 = n_exit; r0 = n_err;
        run_step(2'b10, 10, 0, 2'b00);
        run_step(2'b01, 10, 0, 2'b00);
        run_step(2'b11, 10, 0, 2'b00);
        run_step(2'b00, 12, 0, 2'b00);
        expect_counts("illegal jump", e0, x0, r0, 0, 0, 1);
        run_step(2'b10, 10, 0, 2'b00);
        run_step(2'b11, 10, 0, 2'b00);
        run_step(2'b01, 10, 0, 2'b00);
        run_step(2'b00, 12, 0, 2'b00);
        expect_counts("entry after abort", e0, x0, r0, 1, 0, 1);

        // Reset while in IN_AB, then the car finishes: nothing counted
        e0 = n_enter; x0 = n_exit; r0 = n_err;
        run_step(2'b10, 10, 0, 2'b00);
        run_step(2'b11, 10, 0, 2'b00);
        do_reset(1);
        run_step(2'b01, 10, 0, 2'b00);
        run_step(2'b00, 12, 0, 2'b00);
        expect_counts("reset mid-entry", e0, x0, r0, 0, 0, 0);

        // Random sequences with occasional sub-threshold glitches
        for (int s = 0; s < 40; s++) begin
            rp = 2'($urandom_range(0, 3));
            rh = $urandom_range(12, 16);
            rg = ($urandom_range(0, 2) == 0) ? $urandom_range(1, D - 1) : 0;
            rm = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
            run_step(rp, rh, rg, rm);
        end
        run_step(2'b00, 14, 0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
